// File: rtl/bit_stuff_engine_if.sv
// Input bit stream handshake for the bit stuffing engine.
// The producer drives data; the engine returns a combinational ready.
interface bit_stuff_engine_if;
    logic in_valid;
    logic in_bit;
    logic in_ready;

    modport master (
        output in_valid,
        output in_bit,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output in_ready
    );
endinterface

// File: rtl/bit_stuff_engine.sv
// Bit stuffing engine: inserts a 0 after RUN_LEN consecutive 1s,
// with optional NRZI line encoding and a saturating stuff counter.
module bit_stuff_engine #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 4,
    parameter int NRZI_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_strobe,
    input  logic             stuff_en,
    input  logic             eop,
    bit_stuff_engine_if.slave in_if,
    output logic             out_valid,
    output logic             out_bit,
    output logic             stuffing,
    output logic             line_bit,
    output logic [CNT_W-1:0] run_count,
    output logic [7:0]       stuff_total,
    output logic             underrun
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);

    state_t           state, state_d;
    logic             eop_pending, eop_pending_d;
    logic [CNT_W-1:0] run_d, run_inc;
    logic             ov_d, ob_d, st_d, lb_d, ur_d;
    logic [7:0]       tot_d;
    logic             consume;

    assign in_if.in_ready = bit_strobe & ~eop
                          & (state == IDLE | state == DATA);
    assign consume = in_if.in_ready & in_if.in_valid;
    assign run_inc = (run_count == RUN_MAX) ? run_count
                                            : run_count + 1'b1;

    always_comb begin
        state_d       = state;
        eop_pending_d = eop_pending;
        run_d         = run_count;
        ov_d          = 1'b0;
        ob_d          = out_bit;
        st_d          = 1'b0;
        tot_d         = stuff_total;
        ur_d          = underrun;
        lb_d          = line_bit;
        if (bit_strobe) begin
            unique case (state)
                IDLE, DATA: begin
                    if (consume) begin
                        ov_d    = 1'b1;
                        ob_d    = in_if.in_bit;
                        state_d = DATA;
                        if (in_if.in_bit) begin
                            run_d = run_inc;
                            if (stuff_en && run_inc == RUN_TGT)
                                state_d = STUFF;
                        end else begin
                            run_d = '0;
                        end
                    end else if (eop) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else if (state == DATA) begin
                        ur_d    = 1'b1;
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                STUFF: begin
                    // stuff bit goes out even if stuff_en dropped meanwhile
                    ov_d  = 1'b1;
                    ob_d  = 1'b0;
                    st_d  = 1'b1;
                    run_d = '0;
                    if (stuff_total != 8'hFF)
                        tot_d = stuff_total + 8'd1;
                    state_d = (eop_pending | eop) ? IDLE : DATA;
                    eop_pending_d = 1'b0;
                end
                default: begin
                    state_d       = IDLE;
                    eop_pending_d = 1'b0;
                    run_d         = '0;
                end
            endcase
        end
        if (ov_d)
            lb_d = (NRZI_EN != 0) ? (ob_d ? line_bit : ~line_bit) : ob_d;
        // idle entry restores the idle line level, overriding any toggle
        if (state_d == IDLE && state != IDLE)
            lb_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            eop_pending <= 1'b0;
            run_count   <= '0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            stuffing    <= 1'b0;
            line_bit    <= 1'b1;
            stuff_total <= 8'd0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_d;
            eop_pending <= eop_pending_d;
            run_count   <= run_d;
            out_valid   <= ov_d;
            out_bit     <= ob_d;
            stuffing    <= st_d;
            line_bit    <= lb_d;
            stuff_total <= tot_d;
            underrun    <= ur_d;
        end
    end

endmodule

// File: doc/bit_stuff_engine.md
BIT_STUFF_ENGINE -- requirements
Module: bit_stuff_engine

Interface
REQ-001 SHALL have parameter RUN_LEN, default 6, meaning consecutive 1s that force a stuffed 0 (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning run counter width; 2^CNT_W > RUN_LEN is required.
REQ-003 SHALL have parameter NRZI_EN, default 1, meaning line_bit is NRZI-encoded when 1 and equals out_bit when 0.
REQ-004 SHALL use a single clock and a synchronous, active-high reset, with the ports listed in REQ-005 and REQ-006.
REQ-005 Port: clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-006 Port: rst, input, 1 bit, synchronous active-high reset.
REQ-007 Port: bit_strobe, input, 1 bit, one-cycle pulse marking a bit time; no state changes occur without it, except reset.
REQ-008 Port: stuff_en, input, 1 bit, stuffing enable; when 0 the block acts as a pass-through.
REQ-009 Port: in_valid, input, 1 bit, in_bit holds a valid data bit.
REQ-010 Port: in_bit, input, 1 bit, unstuffed data bit.
REQ-011 Port: in_ready, output, 1 bit, combinational; the bit is consumed when in_valid & in_ready.
REQ-012 Port: eop, input, 1 bit, end of packet; sampled on bit_strobe.
REQ-013 Port: out_valid, output, 1 bit, registered, one-cycle pulse per emitted bit.
REQ-014 Port: out_bit, output, 1 bit, registered, emitted (stuffed) data bit.
REQ-015 Port: stuffing, output, 1 bit, registered, high with out_valid when out_bit is an inserted stuff bit.
REQ-016 Port: line_bit, output, 1 bit, registered, encoded line level; idle level is 1.
REQ-017 Port: run_count, output, CNT_W bits, current count of consecutive emitted 1s.
REQ-018 Port: stuff_total, output, 8 bits, saturating count of inserted stuff bits.
REQ-019 Port: underrun, output, 1 bit, sticky; set when data is missing mid-packet.

Function
REQ-020 SHALL implement three states: IDLE, DATA and STUFF; eop_pending SHALL be a 1-bit flag.
REQ-021 in_ready SHALL equal bit_strobe & ~eop & (state==IDLE | state==DATA).
REQ-022 IDLE, on strobe with in_valid & ~eop: consume bit, emit it, go to DATA; otherwise remain in IDLE, out_valid=0.
REQ-023 DATA, on strobe with in_valid & ~eop: consume the bit and emit out_bit=in_bit, out_valid=1, stuffing=0.
REQ-024 Emitted 1 SHALL set run_count to run_count+1; an emitted 0 SHALL clear run_count.
REQ-025 When stuff_en=1 and an emitted 1 makes run_count==RUN_LEN, the next state SHALL be STUFF.
REQ-026 STUFF, on strobe: emit out_bit=0 with stuffing=1 and out_valid=1, clear run_count, consume nothing (in_ready=0).
REQ-027 STUFF exit: go to IDLE if eop_pending or eop is set, else go to DATA; clear eop_pending.
REQ-028 eop on strobe in STUFF SHALL set eop_pending; the stuff bit is always emitted before returning to IDLE.
REQ-029 eop on strobe in DATA SHALL: go to IDLE, clear run_count, consume no bit, emit nothing.
REQ-030 DATA, on strobe with ~in_valid & ~eop: set underrun, go to IDLE, clear run_count, emit nothing.
REQ-031 stuff_en=0: STUFF is never entered and run_count still tracks (REQ-024), saturating at 2^CNT_W-1.
REQ-032 Clearing stuff_en while in STUFF SHALL NOT abort the pending stuff bit.
REQ-033 NRZI_EN=1: on each out_valid, line_bit toggles if out_bit=0 and holds if out_bit=1.
REQ-034 NRZI_EN=0: line_bit SHALL equal out_bit whenever out_valid is asserted.
REQ-035 line_bit SHALL be forced to 1 on every entry to IDLE.
REQ-036 stuff_total SHALL increment on each stuff bit emitted and hold at 255.
REQ-037 Latency SHALL be one clk from the consuming strobe to the corresponding out_valid.

Reset
REQ-038 rst=1 SHALL set state to IDLE and clear eop_pending, run_count, out_valid, out_bit, stuffing, stuff_total and underrun, and set line_bit to 1, regardless of bit_strobe.
REQ-039 rst during STUFF SHALL discard the pending stuff bit.

Verification
REQ-040 Scenario: RUN_LEN=6, 6 consecutive 1s, then 0 -> out 1,1,1,1,1,1,0(stuffing=1),0; in_ready low on strobe 7; stuff_total=1.
REQ-041 Scenario: 5 consecutive 1s, then 0 -> no stuff bit; run_count 5 then 0; stuff_total=0.
REQ-042 Scenario: eop on the strobe where state==STUFF -> stuff 0 emitted, then IDLE, line_bit=1.
REQ-043 Scenario: in_valid=0 on a strobe in DATA -> underrun=1 (sticky), IDLE, no out_valid.
REQ-044 Scenario: NRZI_EN=1, out bits 1,0,0,1 from idle -> line_bit 1,0,1,1.
REQ-045 Scenario: 300 stuff events -> stuff_total=255; rst mid-STUFF -> all outputs at reset values on the next clk, no stuff bit emitted.
